display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Sequential controller that drives a bank of multiplexed seven-segment displays from a 16-bit binary value. It accepts a value through a ready/load handshake and converts it to five BCD digits with a 16-step shift-add-3 sequence. It commits the digits to a display register and time-multiplexes them onto one shared segment bus with active-low digit enables. It sits between the ALU result path and the board's display pins and replaces per-digit combinational decoding with one shared decoder.

## Interface
- DISPLAYS, 4, number of physical digits driven, legal range 1..5
- REFRESH_DIV, 50000, clock cycles each digit stays enabled, legal range ≥ 2
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- num  input  16  unsigned binary value to display
- load  input  1  request; sampled only when ready=1
- ready  output  1  high in IDLE; load accepted on an edge where ready=1
- done  output  1  one-cycle pulse when a new value is committed
- ovf  output  1  committed value ≥ 10^DISPLAYS
- sseg  output  7  segments, active-high, bit0=a … bit6=g
- an  output  DISPLAYS  digit enables, active-low, one-hot

Single clock domain. Reset is synchronous and active-high.

## Operation
- FSM states: IDLE, CONVERT, COMMIT. Reset state is IDLE.
- IDLE: ready=1. On load=1, capture num into a 16-bit shift register, clear the 20-bit BCD accumulator and step counter, and go to CONVERT.
- CONVERT: one step per cycle. Each BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1. After the 16th step, go to COMMIT.
- COMMIT: copy the 5 BCD nibbles to the display register. Set ovf = (value ≥ 10^DISPLAYS). Pulse done. Return to IDLE.
- load in CONVERT or COMMIT is ignored and is not queued.
- The display register holds the previous committed value throughout CONVERT. The display never shows partial results.
- Scan: a prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→DISPLAYS-1→0. Index 0 is the least significant digit.
- an = ~(1 << index). sseg = encode(display digit[index]).
- Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
- When ovf=1, only the low DISPLAYS digits are shown. Higher digits are dropped.
- The scan logic runs independently of the FSM and is never stalled by conversion.

## Timing
- Reset values: state IDLE, ready=1, done=0, ovf=0, display digits all 0, prescaler 0, index 0, an=~1 (LSB low), sseg=3F.
- Reset asserted mid-conversion: next edge returns to IDLE with the display cleared to 0. No done pulse.
- Load accepted at edge k. ready is low after edge k until edge k+17.
- Conversion steps occur at edges k+1..k+16. Commit occurs at edge k+17.
- done is high for exactly the cycle after edge k+17. ready=1 in that same cycle, so back-to-back loads are allowed: the next load can be accepted at edge k+18.
- Latency from load to new digits visible on sseg: 18 edges, provided the scan index points at the changed digit.
- Each an pattern is held for exactly REFRESH_DIV cycles. A full frame takes DISPLAYS×REFRESH_DIV cycles.
- sseg and an change on the same edge, both driven from registered index and data (no glitching between them).

## Configuration
- DISPLAY_BLANK_LEADING_EN defined: every digit above the most significant nonzero digit, within the displayed range, drives sseg=00 while enabled. Digit 0 is never blanked, so value 0 shows "0".
- Not defined: all DISPLAYS digits always show, including leading zeros (sseg=3F).
- an scanning and timing are identical in both builds.

## Test plan
Bench uses DISPLAYS=4, REFRESH_DIV=4.
- Reset held 2 cycles then released -> ready=1, done=0, ovf=0, an=1110, sseg=3F, an advancing to 1101 after 4 cycles.
- load with num=1234 -> ready low 17 cycles, single done pulse, then sseg/an sequence 66/1110, 4F/1101, 5B/1011, 06/0111, each held 4 cycles.
- load with num=65535 -> ovf=1, displayed digits 5,3,5,5 (sseg 6D, 4F, 6D, 6D from index 0 up).
- load 1234, then load with num=9 two cycles later -> second load ignored, single done pulse, display shows 1234. A subsequent load of 9 in IDLE is accepted.
- rst asserted 8 cycles into conversion of 4321 -> ready=1 next cycle, no done pulse, all digits show 0, ovf=0.
- load with num=7 -> with DISPLAY_BLANK_LEADING_EN: sseg 07 on index 0 and 00 on indices 1-3. Without the macro: 07 then 3F, 3F, 3F.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 16-bit binary to 5-digit BCD converter driving a multiplexed seven-segment bank.
// Optional build macro DISPLAY_BLANK_LEADING_EN blanks leading zero digits.
module display_scan_ctrl #(
    parameter int DISPLAYS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         num,
    input  logic                load,
    output logic                ready,
    output logic                done,
    output logic                ovf,
    output logic [6:0]          sseg,
    output logic [DISPLAYS-1:0] an
);
    localparam int PW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t state, state_n;
    logic [15:0]   shift;
    logic [19:0]   bcd, disp;
    logic [15:0]   adj;
    logic [3:0]    step, cur;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          ovf_n;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0: encode = 7'h3F;
            4'd1: encode = 7'h06;
            4'd2: encode = 7'h5B;
            4'd3: encode = 7'h4F;
            4'd4: encode = 7'h66;
            4'd5: encode = 7'h6D;
            4'd6: encode = 7'h7D;
            4'd7: encode = 7'h07;
            4'd8: encode = 7'h7F;
            4'd9: encode = 7'h6F;
            default: encode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE && load) ? CONVERT :
                  (state == CONVERT && step == 4'd15) ? COMMIT :
                  (state == COMMIT) ? IDLE : state;
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // The top nibble never reaches 5 before the final shift of a 16-bit value, so it needs no adjust.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        ovf_n = 1'b0;
        for (int i = DISPLAYS; i < 5; i++)
            ovf_n = ovf_n | (|bcd[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            bcd   <= '0;
            step  <= '0;
            disp  <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == IDLE && load) begin
                shift <= num;
                bcd   <= '0;
                step  <= '0;
            end else if (state == CONVERT) begin
                {bcd, shift} <= {bcd[18:16], adj, shift, 1'b0};
                step         <= step + 4'd1;
            end
            if (state == COMMIT) begin
                disp <= bcd;
                ovf  <= ovf_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'(DISPLAYS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        cur = disp[{idx, 2'b00} +: 4];
        an  = ~(DISPLAYS'(1) << idx);
`ifdef DISPLAY_BLANK_LEADING_EN
        sseg = (idx != 3'd0 && (disp >> {idx, 2'b00}) == 20'd0) ? 7'h00 : encode(cur);
`else
        sseg = encode(cur);
`endif
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with DISPLAYS=4, REFRESH_DIV=4.
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, load, ready, done, ovf;
    logic [15:0] num;
    logic [6:0]  sseg;
    logic [3:0]  an;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic            ovf;
        logic [3:0][6:0] seg;
    } exp_t;
    exp_t sb[$];

    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         p10 [4]  = '{1, 10, 100, 1000};

    display_scan_ctrl #(.DISPLAYS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .num(num), .load(load), .ready(ready),
        .done(done), .ovf(ovf), .sseg(sseg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        e.ovf = (v >= 10000);
        for (int i = 0; i < 4; i++) begin
            logic blank;
`ifdef DISPLAY_BLANK_LEADING_EN
            blank = (i > 0) && (v / p10[i] == 0);
`else
            blank = 1'b0;
`endif
            e.seg[i] = blank ? 7'h00 : tbl[(v / p10[i]) % 10];
        end
        return e;
    endfunction

    task automatic wait_an(input logic [3:0] p);
        int n = 0;
        while (an !== p && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an !== p) check("an_timeout", an, p);
    endtask

    task automatic verify_frame();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("ovf", ovf, e.ovf);
        wait_an(4'b0111);
        wait_an(4'b1110);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] pat;
            int hold;
            pat = ~(4'b0001 << i);
            hold = 0;
            check("an", an, pat);
            check("sseg", sseg, e.seg[i]);
            while (an === pat && hold < 10) begin
                @(negedge clk);
                hold++;
            end
            check("hold", hold, 4);
        end
    endtask

    task automatic convert(input logic [15:0] v, input int late_at, input logic [15:0] late_v);
        int lows = 0;
        int dones = 0;
        @(negedge clk);
        check("ready_pre", ready, 1);
        num  = v;
        load = 1'b1;
        @(posedge clk);
        sb.push_back(model(v));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!ready) lows++;
            if (done) dones++;
            load = (c == late_at);
            if (c == late_at) num = late_v;
        end
        load = 1'b0;
        check("ready_low", lows, 17);
        check("done_cnt", dones, 1);
        verify_frame();
    endtask

    initial begin
        int n;
        int dones;
        rst  = 1'b1;
        load = 1'b0;
        num  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_an", an, 4'b1110);
        check("rst_sseg", sseg, 7'h3F);
        n = 0;
        while (an === 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_hold", n, 4);
        check("rst_an1", an, 4'b1101);

        convert(16'd1234, -1, 16'd0);
        convert(16'd65535, -1, 16'd0);
        convert(16'd1234, 1, 16'd9);
        convert(16'd9, -1, 16'd0);

        @(negedge clk);
        num  = 16'd4321;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(0));
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_ovf", ovf, 0);
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_rst_dones", dones, 0);
        verify_frame();

        convert(16'd7, -1, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
